sha256_block_sequencer: RTL
===========================

Name: sha256_block_sequencer

Overview:
Controller that sequences the sha256 compression core across multi-block messages. It accepts pre-padded 512-bit blocks over a valid/ready stream and chains each block's result into the next block's H_in. It starts the chain from the SHA-256 initial hash value. After the block flagged last, it returns the 256-bit digest over a valid/ready stream. It sits between the padding front-end and the sha256 core, and later feeds the RIPEMD-160 stage of Hash160.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in WAIT for core_done before a fault is raised.
CNT_W, 16, width of the block counter.

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, reset is synchronous and active-high
blk_valid  input  1  upstream block valid
blk_ready  output  1  sequencer can accept a block
blk_data  input  512  padded message block, word 0 in bits [511:480]
blk_last  input  1  block is final of message; sampled with blk_data
dig_valid  output  1  digest valid
dig_ready  input  1  downstream accepts digest
digest  output  256  final hash
blk_count  output  CNT_W  blocks completed in the current message
busy  output  1  high in any state except IDLE
timeout_err  output  1  sticky core-timeout fault
core_start  output  1  one-cycle start pulse to the core (core input_valid)
core_H_in  output  256  chaining value to the core
core_M_in  output  512  block to the core
core_done  input  1  core output_valid
core_H_out  input  256  core result, feed-forward already added

Behaviour:
- Reset (synchronous, any state, including mid-block):
  - state=IDLE.
  - H_chain=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - blk_ready=1, dig_valid=0, digest=0, blk_count=0, busy=0, timeout_err=0, core_start=0, core_M_in=0, core_H_in=IV.
- States: IDLE, START, WAIT, MID, DONE, ERR.
- IDLE: blk_ready=1. On blk_valid&blk_ready: register blk_data into core_M_in and blk_last into last_r, then go to START.
- MID: same acceptance as IDLE, but H_chain holds the previous result. busy=1.
- START: core_start=1 for exactly this one cycle. core_H_in=H_chain and core_M_in stay stable from START until leaving WAIT. Clear the watchdog counter. Go to WAIT.
- WAIT: watchdog counter increments each cycle.
  - On core_done: H_chain<=core_H_out; blk_count increments, saturating at all-ones.
  - If last_r=1: digest<=core_H_out and go to DONE. Otherwise go to MID.
  - If the counter reaches TIMEOUT_CYCLES with no core_done: go to ERR.
  - If core_done and timeout occur on the same cycle, core_done wins.
- DONE: dig_valid=1; digest stays stable until dig_valid&dig_ready.
  - On that handshake: dig_valid=0, H_chain=IV, blk_count=0, go to IDLE.
  - Handshake can complete in the first DONE cycle.
- ERR: timeout_err=1, blk_ready=0, dig_valid=0. Exit only via rst.
- blk_ready=0 in START, WAIT, DONE and ERR.
- core_done outside WAIT is ignored.
- Latency: digest is valid N*(L+2)+1 cycles after the first block is accepted, for N blocks and core latency L cycles (start to done).
- A single block with blk_last=1 is a one-block message. There is no empty-message case; the padder always emits at least one block.
- Back-to-back messages: after the DONE handshake, the next message's first block can be accepted in the following IDLE cycle.

Test Plan:
- One block "abc" (61626380 00..00 00000018), blk_last=1 -> one core_start pulse with core_H_in=IV; digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; blk_count=1.
- Two blocks "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> second core_H_in equals the first core_H_out; digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; exactly 2 core_start pulses.
- dig_ready held low 20 cycles after "abc" -> dig_valid and digest stable and blk_ready=0 for all 20 cycles; then a second "abc" message yields the same digest, proving H_chain was reset to IV.
- Core model that never asserts core_done -> timeout_err=1 exactly TIMEOUT_CYCLES cycles into WAIT; blk_ready=0 until rst; after rst, "abc" passes.
- rst asserted during WAIT of the first block of a two-block message -> all outputs at reset values next cycle; a late core_done is ignored; a fresh "abc" then gives the correct digest.
- blk_valid toggling with gaps, plus a spurious core_done in IDLE -> no extra core_start pulses; blk_count and digest unaffected.

Source files
------------

// File: rtl/sha256_block_sequencer.sv
// SHA-256 multi-block sequencer: feeds padded 512-bit blocks to the compression
// core, chains each result into the next block's H_in starting from the IV, and
// presents the final digest on a valid/ready stream. A watchdog bounds the wait
// for the core and parks the block in a sticky fault state if it never answers.
module sha256_block_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [511:0]       blk_data,
    input  logic               blk_last,
    output logic               dig_valid,
    input  logic               dig_ready,
    output logic [255:0]       digest,
    output logic [CNT_W-1:0]   blk_count,
    output logic               busy,
    output logic               timeout_err,
    output logic               core_start,
    output logic [255:0]       core_H_in,
    output logic [511:0]       core_M_in,
    input  logic               core_done,
    input  logic [255:0]       core_H_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_MID,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [255:0]       h_chain_q, h_chain_d;
    logic [511:0]       m_q, m_d;
    logic               last_q, last_d;
    logic [255:0]       digest_q, digest_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            h_chain_q <= IV;
            m_q       <= '0;
            last_q    <= 1'b0;
            digest_q  <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            h_chain_q <= h_chain_d;
            m_q       <= m_d;
            last_q    <= last_d;
            digest_q  <= digest_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
        end
    end

    // Next-state logic; core_done takes priority over the watchdog expiring
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_MID: if (blk_valid) state_d = S_START;
            S_START:       state_d = S_WAIT;
            S_WAIT: begin
                if (core_done)            state_d = last_q ? S_DONE : S_MID;
                else if (wd_q == WD_LAST) state_d = S_ERR;
            end
            S_DONE:        if (dig_ready) state_d = S_IDLE;
            S_ERR:         state_d = S_ERR;
            default:       state_d = S_IDLE;
        endcase
    end

    // Datapath updates: block capture, watchdog, chaining, digest and count
    always_comb begin
        h_chain_d = h_chain_q;
        m_d       = m_q;
        last_d    = last_q;
        digest_d  = digest_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        case (state_q)
            S_IDLE, S_MID: begin
                if (blk_valid) begin
                    m_d    = blk_data;
                    last_d = blk_last;
                end
            end
            S_START: wd_d = '0;
            S_WAIT: begin
                if (core_done) begin
                    h_chain_d = core_H_out;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (last_q) digest_d = core_H_out;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                if (dig_ready) begin
                    h_chain_d = IV;
                    cnt_d     = '0;
                end
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        blk_ready   = 1'b0;
        dig_valid   = 1'b0;
        busy        = 1'b1;
        timeout_err = 1'b0;
        core_start  = 1'b0;
        case (state_q)
            S_IDLE: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
            end
            S_MID:   blk_ready   = 1'b1;
            S_START: core_start  = 1'b1;
            S_DONE:  dig_valid   = 1'b1;
            S_ERR:   timeout_err = 1'b1;
            default: ;
        endcase
    end

    assign digest    = digest_q;
    assign blk_count = cnt_q;
    assign core_H_in = h_chain_q;
    assign core_M_in = m_q;

endmodule
